// File: rtl/cntr_pkg.sv
// cntr_pkg: shared constants for the Gray counter slice.
// Direction encodings and the default counter width.
package cntr_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int CNTR_DEF_WIDTH = 4;

endpackage

// File: rtl/cvrt_bin_gry.sv
// cvrt_bin_gry: combinational binary-to-Gray converter.
module cvrt_bin_gry #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_bin,
    output logic [DATA_WIDTH-1:0] o_gry
);

    assign o_gry = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/cntr_gry.sv
// cntr_gry: up/down binary counter with registered Gray output and wrap pulse.
// Define CNTR_GRY_CHK_EN to add the sticky Gray-step error checker (o_err).
module cntr_gry
    import cntr_pkg::*;
#(
    parameter int DATA_WIDTH = CNTR_DEF_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_val,
    output logic [DATA_WIDTH-1:0] o_bin,
    output logic [DATA_WIDTH-1:0] o_gry,
    output logic                  o_wrap
`ifdef CNTR_GRY_CHK_EN
    ,
    output logic                  o_err
`endif
);

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gry_q, gry_d;
    logic                  wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (i_load) begin
            bin_d = i_load_val;
        end else if (i_en) begin
            if (i_dir == DIR_UP) begin
                bin_d  = bin_q + DATA_WIDTH'(1);
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - DATA_WIDTH'(1);
                wrap_d = ~|bin_q;
            end
        end
    end

    // Gray is derived from next-state binary so both register on the same edge
    cvrt_bin_gry #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cvrt (
        .i_bin(bin_d),
        .o_gry(gry_d)
    );

`ifdef CNTR_GRY_CHK_EN
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] step_diff;
    logic                  ld_q;
    logic                  err_q, err_d;

    // x & (x-1) is nonzero exactly when more than one bit of x is set
    assign step_diff = gry_q ^ prev_q;
    assign err_d     = err_q | (~ld_q & (|(step_diff & (step_diff - DATA_WIDTH'(1)))));
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bin_q  <= '0;
            gry_q  <= '0;
            wrap_q <= 1'b0;
`ifdef CNTR_GRY_CHK_EN
            prev_q <= '0;
            ld_q   <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            bin_q  <= bin_d;
            gry_q  <= gry_d;
            wrap_q <= wrap_d;
`ifdef CNTR_GRY_CHK_EN
            prev_q <= gry_q;
            ld_q   <= i_load;
            err_q  <= err_d;
`endif
        end
    end

    assign o_bin  = bin_q;
    assign o_gry  = gry_q;
    assign o_wrap = wrap_q;
`ifdef CNTR_GRY_CHK_EN
    assign o_err  = err_q;
`endif

endmodule

// File: tb/tb_cntr_gry.sv
// tb_cntr_gry: self-checking bench for cntr_gry (DATA_WIDTH=4).
// Define CNTR_GRY_CHK_EN to also exercise o_err.
module tb_cntr_gry;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin;
    logic [W-1:0] gry;
    logic         wrap;
`ifdef CNTR_GRY_CHK_EN
    logic         err;
`endif

    int total = 0;
    int bad   = 0;
    int m_bin = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    cntr_gry #(
        .DATA_WIDTH(W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_dir     (dir),
        .i_load    (load),
        .i_load_val(load_val),
        .o_bin     (bin),
        .o_gry     (gry),
        .o_wrap    (wrap)
`ifdef CNTR_GRY_CHK_EN
        ,
        .o_err     (err)
`endif
    );

    function automatic logic [W-1:0] to_gry(input int b);
        logic [W-1:0] v;
        v = b[W-1:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [W-1:0] gry2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int ones(input logic [W-1:0] x);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(x[i]);
        return n;
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge
    task automatic cycle(input bit ld, input int val, input bit e, input bit d);
        load     = ld;
        load_val = val[W-1:0];
        en       = e;
        dir      = d;
        m_wrap   = 1'b0;
        if (ld) begin
            m_bin = val % MOD;
        end else if (e) begin
            if (!d) begin
                m_wrap = (m_bin == MOD - 1);
                m_bin  = (m_bin + 1) % MOD;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + MOD - 1) % MOD;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        m_bin = 0; m_wrap = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bin !== '0 || gry !== '0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL reset: bin=%b gry=%b wrap=%b want 0000/0000/0", bin, gry, wrap);
        end
`ifdef CNTR_GRY_CHK_EN
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: err=%b want 0", err);
        end
`endif
    endtask

    task automatic test_up_sweep();
        logic [W-1:0] exp_g [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                     4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                     4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                     4'b1011, 4'b1001, 4'b1000, 4'b0000};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 0, 1'b1, 1'b0);
            total++;
            if (gry !== exp_g[i] || wrap !== (i == 15)) begin
                bad++;
                $display("FAIL up_sweep[%0d]: gry=%b wrap=%b want %b/%0d",
                         i, gry, wrap, exp_g[i], (i == 15));
            end
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        cycle(1'b0, 0, 1'b1, 1'b1);
        total++;
        if (bin !== 4'b1111 || gry !== 4'b1000 || wrap !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap: bin=%b gry=%b wrap=%b want 1111/1000/1", bin, gry, wrap);
        end
        cycle(1'b0, 0, 1'b1, 1'b1);
        total++;
        if (bin !== 4'b1110 || gry !== 4'b1001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL down_step: bin=%b gry=%b wrap=%b want 1110/1001/0", bin, gry, wrap);
        end
    endtask

    task automatic test_load();
        cycle(1'b1, 5, 1'b1, 1'b0);
        total++;
        if (bin !== 4'b0101 || gry !== 4'b0111 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_0101: bin=%b gry=%b wrap=%b want 0101/0111/0", bin, gry, wrap);
        end
        cycle(1'b1, 15, 1'b1, 1'b0);
        cycle(1'b1, 15, 1'b1, 1'b0);
        total++;
        if (bin !== 4'b1111 || gry !== 4'b1000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_ones: bin=%b gry=%b wrap=%b want 1111/1000/0", bin, gry, wrap);
        end
        cycle(1'b1, 0, 1'b1, 1'b1);
        total++;
        if (bin !== 4'b0000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL load_zero_dn: bin=%b wrap=%b want 0000/0", bin, wrap);
        end
    endtask

    task automatic test_hold();
        cycle(1'b1, 6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, 1'b0, i[0]);
            total++;
            if (bin !== 4'b0110 || gry !== 4'b0101 || wrap !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: bin=%b gry=%b wrap=%b want 0110/0101/0",
                         i, bin, gry, wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 11, 1'b0, 1'b0);
        en = 1'b1;
        dir = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (bin !== '0 || gry !== '0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: bin=%b gry=%b wrap=%b want 0000/0000/0", bin, gry, wrap);
        end
        #1;
        rst = 1'b0;
        m_bin = 0;
        cycle(1'b0, 0, 1'b1, 1'b0);
        total++;
        if (bin !== 4'b0001 || gry !== 4'b0001 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL resume: bin=%b gry=%b wrap=%b want 0001/0001/0", bin, gry, wrap);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] prev_g;
        bit ld, e, d;
        int v;
        do_reset();
        prev_g = gry;
        for (int i = 0; i < 300; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1) == 1;
            v  = int'($urandom_range(0, MOD - 1));
            cycle(ld, v, e, d);
            total++;
            if (bin !== m_bin[W-1:0] || gry !== to_gry(m_bin) || wrap !== m_wrap) begin
                bad++;
                $display("FAIL random[%0d]: bin=%b gry=%b wrap=%b want %b/%b/%0d",
                         i, bin, gry, wrap, m_bin[W-1:0], to_gry(m_bin), m_wrap);
            end
            if (!ld) begin
                total++;
                if (ones(gry ^ prev_g) != (e ? 1 : 0)) begin
                    bad++;
                    $display("FAIL gray_step[%0d]: %b -> %b bits=%0d want %0d",
                             i, prev_g, gry, ones(gry ^ prev_g), (e ? 1 : 0));
                end
            end
            prev_g = gry;
        end
    endtask

`ifdef CNTR_GRY_CHK_EN
    task automatic test_err_sweep();
        do_reset();
        for (int i = 0; i < 70; i++) begin
            if (i < 20)      cycle(1'b0, 0, 1'b1, 1'b0);
            else if (i < 45) cycle(1'b0, 0, 1'b1, 1'b1);
            else if (i < 55) cycle(1'b0, 0, 1'b1, i[0]);
            else if (i == 55) cycle(1'b1, 0, 1'b1, 1'b0);
            else if (i == 56) cycle(1'b1, 10, 1'b1, 1'b0);
            else             cycle(1'b0, 0, 1'b1, i[1]);
            total++;
            if (err !== 1'b0 || gry2bin(gry) !== bin || bin !== m_bin[W-1:0]) begin
                bad++;
                $display("FAIL err_sweep[%0d]: err=%b dec=%b bin=%b want 0/%b",
                         i, err, gry2bin(gry), bin, m_bin[W-1:0]);
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load();
        test_hold();
        test_async_reset();
        test_random();
`ifdef CNTR_GRY_CHK_EN
        test_err_sweep();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cntr_gry.md
CNTR_GRY -- requirements
Module: cntr_gry

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: i_en  input  1  count enable; one step per cycle when high.
REQ-005 SHALL have port: i_dir  input  1  direction; 0 = up, 1 = down.
REQ-006 SHALL have port: i_load  input  1  synchronous load strobe.
REQ-007 SHALL have port: i_load_val  input  DATA_WIDTH  binary load value.
REQ-008 SHALL have port: o_bin  output  DATA_WIDTH  registered binary count.
REQ-009 SHALL have port: o_gry  output  DATA_WIDTH  registered Gray count, always equal to o_bin ^ (o_bin >> 1); feeds cvrt_gry_bin.i_gry.
REQ-010 SHALL have port: o_wrap  output  1  registered one-cycle wrap pulse.
REQ-011 SHALL have port: o_err  output  1  registered Gray-step error flag; present only with CNTR_GRY_CHK_EN.

Function
REQ-012 SHALL give next-state priority: i_load > i_en > hold.
REQ-013 SHALL, on i_load=1, set o_bin = i_load_val and o_gry = Gray(i_load_val) at the next edge, o_wrap=0, regardless of i_en/i_dir.
REQ-014 SHALL, on i_en=1 and i_dir=0, set o_bin = (o_bin+1) mod 2^DATA_WIDTH.
REQ-015 SHALL, on i_en=1 and i_dir=1, set o_bin = (o_bin-1) mod 2^DATA_WIDTH.
REQ-016 SHALL assert o_wrap for exactly the cycle after an up step from all-ones to zero, or a down step from zero to all-ones; o_wrap=0 otherwise.
REQ-017 SHALL hold o_bin and o_gry with o_wrap=0 when i_load=0 and i_en=0.
REQ-018 SHALL update o_bin, o_gry, o_wrap on the same edge: one-cycle latency from inputs; o_gry SHALL be computed from next-state binary, not from the registered o_bin, so o_gry never lags o_bin.
REQ-019 SHALL change exactly one bit of o_gry per counting step, including wrap steps; direction change between consecutive cycles is legal and SHALL also produce single-bit changes.

Reset
REQ-020 SHALL, while i_rst=1, immediately drive o_bin=0, o_gry=0, o_wrap=0, o_err=0, independent of i_clk.
REQ-021 SHALL, on reset asserted mid-count, discard the in-flight step; first edge after deassertion SHALL apply normal next-state rules from zero.

Configuration
REQ-022 SHALL, with macro CNTR_GRY_CHK_EN defined, register the previous o_gry and set o_err (sticky until reset) if two consecutive o_gry values differ in more than one bit, excluding the cycle following a load.
REQ-023 SHALL, without CNTR_GRY_CHK_EN, omit the checker registers and the o_err port entirely.

Structure
REQ-024 SHALL place in shared package cntr_pkg: DIR_UP=1'b0, DIR_DN=1'b1 constants and the default width constant.
REQ-025 SHALL instantiate one sub-module cvrt_bin_gry (combinational binary-to-Gray, parameter DATA_WIDTH) on the next-state binary value.
REQ-026 SHALL implement the whole counter in one always_ff block with async reset plus combinational next-state logic; no latches.

Verification (DATA_WIDTH=4)
REQ-027 SHALL check: reset, i_en=1, i_dir=0 for 16 cycles -> o_gry 0001,0011,0010,0110,...,1000,0000; o_wrap=1 only on the 1111->0000 step.
REQ-028 SHALL check: from reset, i_en=1, i_dir=1 one cycle -> o_bin=1111, o_gry=1000, o_wrap=1; next down step -> o_bin=1110, o_gry=1001, o_wrap=0.
REQ-029 SHALL check: i_load=1, i_en=1, i_load_val=0101 -> o_bin=0101, o_gry=0111, o_wrap=0; load at all-ones with i_en=1 -> no wrap.
REQ-030 SHALL check: i_en=0 for 5 cycles at o_bin=0110 -> o_bin=0110, o_gry=0101 held, o_wrap=0.
REQ-031 SHALL check: i_rst pulsed between edges at o_bin=1011 -> o_bin=o_gry=0 before next edge; counting resumes 0001 after release.
REQ-032 SHALL check with CNTR_GRY_CHK_EN: full up/down sweep with direction flips and a load of 1010 from 0000 -> o_err stays 0; gry output piped through cvrt_gry_bin matches o_bin every cycle.
